// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if
//   Bundles the request inputs and lamp/status outputs of the intersection
//   sequencer.
//   master : request source / status consumer (sensor side, testbench)
//   slave  : the scheduler itself
//   Signals:
//     ns_req, ew_req, ped_req : synchronised demand inputs
//     ns_light, ew_light      : light heads, 100 red / 010 yellow / 001 green
//     walk                    : pedestrian walk lamp
//     phase                   : current state code (debug/status)
//     pending                 : latched requests {ped, ew, ns}
interface traffic_phase_scheduler_if;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic [2:0] pending;

  modport master (
    output ns_req, ew_req, ped_req,
    input  ns_light, ew_light, walk, phase, pending
  );

  modport slave (
    input  ns_req, ew_req, ped_req,
    output ns_light, ew_light, walk, phase, pending
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-driven intersection sequencer. Round-robin service of NS, EW and
//   an exclusive pedestrian phase, with min/max green, yellow and all-red
//   clearance. All outputs are registered and change with the state.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     io_tps : slave side of traffic_phase_scheduler_if (requests in,
//              lights/walk/phase/pending out)
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ALL_RED    | clearance, both heads red; grants next phase
//   NS_GREEN   | NS green, rests here when nothing conflicts
//   NS_YELLOW  | NS yellow, then ALL_RED
//   EW_GREEN   | EW green, rests here when nothing conflicts
//   EW_YELLOW  | EW yellow, then ALL_RED
//   PED_WALK   | both heads red, walk lamp on, then ALL_RED
//   6 / 7      | illegal, recover to ALL_RED next cycle
module traffic_phase_scheduler #(
  parameter int TW           = 32,
  parameter int MIN_GREEN    = 50,
  parameter int MAX_GREEN    = 200,
  parameter int YELLOW_TIME  = 10,
  parameter int ALL_RED_TIME = 4,
  parameter int WALK_TIME    = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  traffic_phase_scheduler_if.slave io_tps
);

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } state_t;

  localparam logic [1:0] L_NS  = 2'd0;
  localparam logic [1:0] L_EW  = 2'd1;
  localparam logic [1:0] L_PED = 2'd2;

  localparam logic [TW-1:0] C_MIN_M1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] C_MAX_M1  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] C_YEL_M1  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] C_AR_M1   = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] C_WALK_M1 = TW'(WALK_TIME - 1);
  localparam logic [TW-1:0] C_SAT     = {TW{1'b1}};

  // State held as raw bits so the illegal codes 6/7 are representable and
  // the recovery path is real logic rather than unreachable.
  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_pending;
  logic [1:0]    r_last;
  logic [2:0]    r_ns_light;
  logic [2:0]    r_ew_light;
  logic          r_walk;
  logic [2:0]    r_phase;

  logic [2:0]    w_req;
  logic [2:0]    w_pend;
  logic [2:0]    w_clr;
  logic [2:0]    w_next;
  logic [2:0]    w_grant;
  logic [1:0]    w_grant_last;
  logic          w_ns_go;
  logic          w_ew_go;
  logic [2:0]    w_ns_light;
  logic [2:0]    w_ew_light;
  logic          w_walk;

  // Own request is masked while that direction is green, so it cannot
  // re-latch against itself.
  assign w_req  = {io_tps.ped_req,
                   io_tps.ew_req & (r_state != EW_GREEN),
                   io_tps.ns_req & (r_state != NS_GREEN)};
  assign w_pend = r_pending | w_req;

  assign w_ns_go = (r_timer >= C_MIN_M1) && (w_pend[1] || w_pend[2]) &&
                   (!io_tps.ns_req || (r_timer >= C_MAX_M1));
  assign w_ew_go = (r_timer >= C_MIN_M1) && (w_pend[0] || w_pend[2]) &&
                   (!io_tps.ew_req || (r_timer >= C_MAX_M1));

  // Round-robin pick starting after the last served phase; NS green is the
  // rest phase when nothing is pending.
  always_comb begin
    w_grant      = NS_GREEN;
    w_grant_last = L_NS;
    case (r_last)
      L_NS: begin
        if (w_pend[1])      begin w_grant = EW_GREEN; w_grant_last = L_EW;  end
        else if (w_pend[2]) begin w_grant = PED_WALK; w_grant_last = L_PED; end
        else if (w_pend[0]) begin w_grant = NS_GREEN; w_grant_last = L_NS;  end
      end
      L_EW: begin
        if (w_pend[2])      begin w_grant = PED_WALK; w_grant_last = L_PED; end
        else if (w_pend[0]) begin w_grant = NS_GREEN; w_grant_last = L_NS;  end
        else if (w_pend[1]) begin w_grant = EW_GREEN; w_grant_last = L_EW;  end
      end
      default: begin
        if (w_pend[0])      begin w_grant = NS_GREEN; w_grant_last = L_NS;  end
        else if (w_pend[1]) begin w_grant = EW_GREEN; w_grant_last = L_EW;  end
        else if (w_pend[2]) begin w_grant = PED_WALK; w_grant_last = L_PED; end
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ALL_RED:   if (r_timer == C_AR_M1)   w_next = w_grant;
      NS_GREEN:  if (w_ns_go)              w_next = NS_YELLOW;
      NS_YELLOW: if (r_timer == C_YEL_M1)  w_next = ALL_RED;
      EW_GREEN:  if (w_ew_go)              w_next = EW_YELLOW;
      EW_YELLOW: if (r_timer == C_YEL_M1)  w_next = ALL_RED;
      PED_WALK:  if (r_timer == C_WALK_M1) w_next = ALL_RED;
      default:                             w_next = ALL_RED;
    endcase
  end

  // Clear on the entering edge only; clear beats a same-cycle set.
  assign w_clr = {(w_next == PED_WALK) && (r_state != PED_WALK),
                  (w_next == EW_GREEN) && (r_state != EW_GREEN),
                  (w_next == NS_GREEN) && (r_state != NS_GREEN)};

  // Lamps decoded from the next state so they register alongside it.
  always_comb begin
    w_ns_light = 3'b100;
    w_ew_light = 3'b100;
    w_walk     = 1'b0;
    case (w_next)
      NS_GREEN:  w_ns_light = 3'b001;
      NS_YELLOW: w_ns_light = 3'b010;
      EW_GREEN:  w_ew_light = 3'b001;
      EW_YELLOW: w_ew_light = 3'b010;
      PED_WALK:  w_walk     = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ALL_RED;
      r_timer    <= '0;
      r_pending  <= 3'b000;
      r_last     <= L_NS;
      r_ns_light <= 3'b100;
      r_ew_light <= 3'b100;
      r_walk     <= 1'b0;
      r_phase    <= ALL_RED;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_timer <= '0;
      else if (r_timer != C_SAT)
        r_timer <= r_timer + TW'(1);
      r_pending <= w_pend & ~w_clr;
      if ((r_state == ALL_RED) && (w_next != ALL_RED))
        r_last <= w_grant_last;
      r_ns_light <= w_ns_light;
      r_ew_light <= w_ew_light;
      r_walk     <= w_walk;
      r_phase    <= w_next;
    end
  end

  assign io_tps.ns_light = r_ns_light;
  assign io_tps.ew_light = r_ew_light;
  assign io_tps.walk     = r_walk;
  assign io_tps.phase    = r_phase;
  assign io_tps.pending  = r_pending;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
//   Directed bench for traffic_phase_scheduler with small timing parameters
//   (MIN 4, MAX 8, YELLOW 2, ALL_RED 1, WALK 3), plus a per-cycle safety
//   monitor and a random request soak.
module tb_traffic_phase_scheduler;
  localparam logic [2:0] P_AR  = 3'd0;
  localparam logic [2:0] P_NSG = 3'd1;
  localparam logic [2:0] P_NSY = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_PED = 3'd5;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b1;
  logic [2:0] prev_ph = 3'd7;
  int   walk_cnt = 0;

  logic [2:0] seq2 [7]  = '{P_NSG, P_NSG, P_NSG, P_NSY, P_NSY, P_AR, P_EWG};
  logic [2:0] seq3 [8]  = '{P_NSG, P_NSG, P_NSG, P_NSG, P_NSG, P_NSG, P_NSG, P_NSY};
  logic [2:0] seq4 [12] = '{P_EWG, P_EWG, P_EWG, P_EWG, P_EWY, P_EWY,
                            P_AR, P_PED, P_PED, P_PED, P_AR, P_NSG};

  traffic_phase_scheduler_if tps ();

  traffic_phase_scheduler #(
    .TW(16), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_TIME(2),
    .ALL_RED_TIME(1), .WALK_TIME(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_tps (tps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ph(input string tag, input logic [2:0] ph);
    logic [2:0] e_ns;
    logic [2:0] e_ew;
    e_ns = (ph == P_NSG) ? 3'b001 : (ph == P_NSY) ? 3'b010 : 3'b100;
    e_ew = (ph == P_EWG) ? 3'b001 : (ph == P_EWY) ? 3'b010 : 3'b100;
    chk({tag, "_phase"}, 32'(tps.phase), 32'(ph));
    chk({tag, "_ns"},    32'(tps.ns_light), 32'(e_ns));
    chk({tag, "_ew"},    32'(tps.ew_light), 32'(e_ew));
    chk({tag, "_walk"},  32'(tps.walk), 32'(ph == P_PED));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tps.ns_req = 1'b0;
    tps.ew_req = 1'b0;
    tps.ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic legal_move(input logic [2:0] from, input logic [2:0] to);
    case (from)
      P_AR:                return (to == P_NSG) || (to == P_EWG) || (to == P_PED);
      P_NSG:               return to == P_NSY;
      P_EWG:               return to == P_EWY;
      P_NSY, P_EWY, P_PED: return to == P_AR;
      default:             return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_ph = 3'd7;
    end else begin
      total++;
      assert (!(tps.ns_light != 3'b100 && tps.ew_light != 3'b100)) else begin
        bad++;
        $error("FAIL inv_both_open ns=%b ew=%b expected one red", tps.ns_light, tps.ew_light);
      end
      total++;
      assert (!tps.walk || (tps.ns_light == 3'b100 && tps.ew_light == 3'b100)) else begin
        bad++;
        $error("FAIL inv_walk_red ns=%b ew=%b expected both 100", tps.ns_light, tps.ew_light);
      end
      if (prev_ph != 3'd7 && tps.phase != prev_ph) begin
        total++;
        assert (legal_move(prev_ph, tps.phase)) else begin
          bad++;
          $error("FAIL inv_sequence from=%0d to=%0d expected legal successor", prev_ph, tps.phase);
        end
      end
      prev_ph = tps.phase;
      if (tps.walk) walk_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    tps.ns_req = 1'b0;
    tps.ew_req = 1'b0;
    tps.ped_req = 1'b0;

    // reset release, no demand: one ALL_RED cycle then NS rests
    do_reset();
    chk_ph("t1_reset", P_AR);
    chk("t1_pend0", 32'(tps.pending), 32'd0);
    step();
    chk_ph("t1_nsg", P_NSG);
    repeat (24) step();
    chk_ph("t1_rest", P_NSG);
    chk("t1_pend_rest", 32'(tps.pending), 32'd0);

    // ew pulse at timer 0, ns low: min green then yellow, all-red, EW
    do_reset();
    step();
    tps.ew_req = 1'b1;
    step();
    tps.ew_req = 1'b0;
    chk("t2_pend_ew", 32'(tps.pending), 32'b010);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      chk_ph($sformatf("t2_c%0d", i), seq2[i]);
    end
    chk("t2_pend_clr", 32'(tps.pending), 32'd0);
    repeat (3) step();
    chk_ph("t2_ew_rest", P_EWG);

    // ns held high with ew pending: green capped at 8 cycles
    do_reset();
    step();
    tps.ns_req = 1'b1;
    tps.ew_req = 1'b1;
    step();
    tps.ew_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk_ph($sformatf("t3_c%0d", i), seq3[i]);
      if (i == 6) chk("t3_pend_own_masked", 32'(tps.pending), 32'b010);
    end
    tps.ns_req = 1'b0;

    // all three during ALL_RED, last=NS: EW, PED, NS
    do_reset();
    tps.ns_req = 1'b1;
    tps.ew_req = 1'b1;
    tps.ped_req = 1'b1;
    step();
    tps.ns_req = 1'b0;
    tps.ew_req = 1'b0;
    tps.ped_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      chk_ph($sformatf("t4_c%0d", i), seq4[i]);
      if (i == 0)  chk("t4_pend_a", 32'(tps.pending), 32'b101);
      if (i == 7)  chk("t4_pend_b", 32'(tps.pending), 32'b001);
      if (i == 11) chk("t4_pend_c", 32'(tps.pending), 32'b000);
    end

    // asynchronous reset mid NS_YELLOW
    do_reset();
    step();
    tps.ew_req = 1'b1;
    step();
    tps.ew_req = 1'b0;
    repeat (3) step();
    chk_ph("t5_yellow", P_NSY);
    chk("t5_pend_pre", 32'(tps.pending), 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ph("t5_async", P_AR);
    chk("t5_pend_async", 32'(tps.pending), 32'd0);
    #2;
    rst_n = 1'b1;
    chk_ph("t5_rel", P_AR);
    step();
    chk_ph("t5_rel_nsg", P_NSG);

    // illegal state code recovers to ALL_RED
    do_reset();
    repeat (4) step();
    mon_en = 1'b0;
    #1;
    force dut.r_state = 3'd7;
    #1;
    release dut.r_state;
    step();
    chk_ph("t6_recover", P_AR);
    step();
    chk_ph("t6_resume", P_NSG);
    mon_en = 1'b1;

    // random demand soak under the safety monitor
    walk_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      tps.ns_req  = ($urandom_range(0, 7) == 0);
      tps.ew_req  = ($urandom_range(0, 7) == 0);
      tps.ped_req = ($urandom_range(0, 15) == 0);
      step();
    end
    chk("t7_walk_seen", 32'(walk_cnt > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven intersection sequencer. It arbitrates among North-South vehicle, East-West vehicle and pedestrian requests and drives both light heads plus a walk signal.
- Service is round-robin with min/max green timing, yellow, all-red clearance and an exclusive pedestrian phase.
- It sits between the sensor synchronisers and the lamp drivers, and supersedes fixed-cycle sequencing at actuated intersections.

Parameters:
- TW, 32, width of the phase timer; every *_TIME value must fit in TW bits.
- MIN_GREEN, 50, minimum green duration in cycles (>=1).
- MAX_GREEN, 200, green duration cap while another request is pending (>=MIN_GREEN).
- YELLOW_TIME, 10, yellow duration in cycles (>=1).
- ALL_RED_TIME, 4, all-red clearance in cycles (>=1).
- WALK_TIME, 40, pedestrian walk duration in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ns_req  in  1  NS vehicle demand, level, already synchronised.
- ew_req  in  1  EW vehicle demand, level, already synchronised.
- ped_req  in  1  pedestrian button, level or pulse, already synchronised.
- ns_light  out  3  NS head: 100 red, 010 yellow, 001 green.
- ew_light  out  3  EW head, same encoding.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding, for debug/status.
- pending  out  3  latched requests {ped,ew,ns}.

Behaviour:
- Reset (rst_n low, asynchronous): state ALL_RED, timer 0, pending 000, last_served NS, ns_light=ew_light=100, walk 0.
- All outputs are registered and change on the same edge as the state.
- States and encoding: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5. Values 6/7 are illegal and recover to ALL_RED next cycle with both heads red.
- Timer:
  - Cleared on every state change; otherwise increments by 1.
  - Saturates at all-ones and never wraps.
  - A state with duration N lasts exactly N cycles: it exits when timer==N-1.
- Request latching:
  - pending[i] is set on any cycle its request input is high.
  - pending[i] is cleared on the edge entering that phase's green or walk state.
  - If set and clear occur in the same cycle, clear wins. A still-high level input re-sets the bit on the next cycle.
- ALL_RED exit (after ALL_RED_TIME cycles):
  - Grant the first pending bit in round-robin order after last_served. Order is NS -> EW -> PED -> NS.
  - If nothing is pending, enter NS_GREEN as the rest phase.
  - last_served is updated to the granted phase.
- Green states (NS_GREEN / EW_GREEN):
  - Exit to the matching yellow only when timer>=MIN_GREEN-1 AND some other pending bit is set AND (own request input low OR timer>=MAX_GREEN-1).
  - With no conflicting demand, green rests indefinitely.
  - The own request input is ignored for latching while in its own green, so pending[own] stays 0.
- Yellow states: after YELLOW_TIME cycles go to ALL_RED.
- PED_WALK:
  - Both heads red, walk=1.
  - After WALK_TIME cycles go directly to ALL_RED with walk=0; there is no yellow.
- Safety invariants, checked every cycle:
  - Never both heads non-red.
  - walk=1 implies both heads red.
  - Every green is followed by yellow, then ALL_RED.
- Simultaneous requests: all latch; service order follows the round-robin pointer, so no requester is served twice before another pending one.

Test Plan:
All scenarios use MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2, ALL_RED_TIME=1, WALK_TIME=3.
- Reset release, no requests -> 1 cycle ALL_RED (both 100), then NS_GREEN (ns 001, ew 100) held for 20+ cycles; pending stays 000.
- In NS_GREEN with ns_req low, pulse ew_req for 1 cycle at timer=0 -> NS green for 4 cycles, yellow 2, all-red 1, then EW_GREEN; pending[1] cleared on entry.
- In NS_GREEN with ns_req held high, ew_req pulsed -> green extends to exactly 8 cycles (MAX_GREEN), then NS_YELLOW.
- ns_req, ew_req, ped_req all pulsed during ALL_RED with last_served=NS -> grant order EW, PED, NS. Walk is high for exactly 3 cycles with both heads 100, and walk exits straight to ALL_RED.
- Assert rst_n low mid NS_YELLOW, asynchronously between edges -> outputs go to both 100, walk 0, pending 000 immediately, without waiting for a clock edge. After release, the reset sequence repeats.
- Force the state register to 7 -> next edge ALL_RED, both heads 100. The safety invariant assertions stay clean across a 10k-cycle random request run.
